// File: rtl/tlb_array.sv
// Fully associative TLB with two combinational search ports, one write port and one read port.
// Each entry maps a VPN pair (even/odd page) to two PFN/attribute halves.
module tlb_array #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic        clk,
  input  logic        reset,
  // search port 0 (fetch)
  input  logic [18:0] s0_vpn2,
  input  logic        s0_odd_page,
  input  logic [7:0]  s0_asid,
  output logic        s0_found,
  output logic [3:0]  s0_index,
  output logic [19:0] s0_pfn,
  output logic [2:0]  s0_c,
  output logic        s0_d,
  output logic        s0_v,
  // search port 1 (data / tlbp)
  input  logic [18:0] s1_vpn2,
  input  logic        s1_odd_page,
  input  logic [7:0]  s1_asid,
  output logic        s1_found,
  output logic [3:0]  s1_index,
  output logic [19:0] s1_pfn,
  output logic [2:0]  s1_c,
  output logic        s1_d,
  output logic        s1_v,
  // write port
  input  logic        we,
  input  logic [3:0]  w_index,
  input  logic [18:0] w_vpn2,
  input  logic [7:0]  w_asid,
  input  logic        w_g,
  input  logic [19:0] w_pfn0,
  input  logic [2:0]  w_c0,
  input  logic        w_d0,
  input  logic        w_v0,
  input  logic [19:0] w_pfn1,
  input  logic [2:0]  w_c1,
  input  logic        w_d1,
  input  logic        w_v1,
  // read port
  input  logic [3:0]  r_index,
  output logic [18:0] r_vpn2,
  output logic [7:0]  r_asid,
  output logic        r_g,
  output logic [19:0] r_pfn0,
  output logic [2:0]  r_c0,
  output logic        r_d0,
  output logic        r_v0,
  output logic [19:0] r_pfn1,
  output logic [2:0]  r_c1,
  output logic        r_d1,
  output logic        r_v1
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  tlb_entry_t entry_q [TLBNUM];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        entry_q[i] <= '0;
      end
    end else if (we) begin
      entry_q[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                            pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                            pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
    end
  end

  // Both search ports share one lookup description.
  logic [18:0] s_vpn2  [2];
  logic        s_odd   [2];
  logic [7:0]  s_asid  [2];
  logic        s_found [2];
  logic [3:0]  s_index [2];
  logic [19:0] s_pfn   [2];
  logic [2:0]  s_c     [2];
  logic        s_d     [2];
  logic        s_v     [2];

  assign s_vpn2[0] = s0_vpn2;
  assign s_odd[0]  = s0_odd_page;
  assign s_asid[0] = s0_asid;
  assign s_vpn2[1] = s1_vpn2;
  assign s_odd[1]  = s1_odd_page;
  assign s_asid[1] = s1_asid;

  for (genvar p = 0; p < 2; p++) begin : g_search
    always_comb begin
      s_found[p] = 1'b0;
      s_index[p] = '0;
      s_pfn[p]   = '0;
      s_c[p]     = '0;
      s_d[p]     = 1'b0;
      s_v[p]     = 1'b0;
      // Scan downward so the lowest matching index is the one that sticks.
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (entry_q[i].vpn2 == s_vpn2[p] &&
            (entry_q[i].g || entry_q[i].asid == s_asid[p])) begin
          s_found[p] = 1'b1;
          s_index[p] = 4'(i);
          s_pfn[p]   = s_odd[p] ? entry_q[i].pfn1 : entry_q[i].pfn0;
          s_c[p]     = s_odd[p] ? entry_q[i].c1   : entry_q[i].c0;
          s_d[p]     = s_odd[p] ? entry_q[i].d1   : entry_q[i].d0;
          s_v[p]     = s_odd[p] ? entry_q[i].v1   : entry_q[i].v0;
        end
      end
    end
  end

  assign s0_found = s_found[0];
  assign s0_index = s_index[0];
  assign s0_pfn   = s_pfn[0];
  assign s0_c     = s_c[0];
  assign s0_d     = s_d[0];
  assign s0_v     = s_v[0];
  assign s1_found = s_found[1];
  assign s1_index = s_index[1];
  assign s1_pfn   = s_pfn[1];
  assign s1_c     = s_c[1];
  assign s1_d     = s_d[1];
  assign s1_v     = s_v[1];

  assign r_vpn2 = entry_q[r_index].vpn2;
  assign r_asid = entry_q[r_index].asid;
  assign r_g    = entry_q[r_index].g;
  assign r_pfn0 = entry_q[r_index].pfn0;
  assign r_c0   = entry_q[r_index].c0;
  assign r_d0   = entry_q[r_index].d0;
  assign r_v0   = entry_q[r_index].v0;
  assign r_pfn1 = entry_q[r_index].pfn1;
  assign r_c1   = entry_q[r_index].c1;
  assign r_d1   = entry_q[r_index].d1;
  assign r_v1   = entry_q[r_index].v1;

endmodule

// File: tb/tb_tlb_array.sv
// Directed bench for tlb_array: search hits/misses, global pages, priority, write/read hazards,
// dual-port independence and reset behaviour.
module tb_tlb_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we;
  logic [3:0]  w_index, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0]  w_asid, r_asid;
  logic        w_g, r_g;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  w_c0, w_c1, r_c0, r_c1;
  logic        w_d0, w_d1, w_v0, w_v1, r_d0, r_d1, r_v0, r_v1;

  int errors = 0;
  int checks = 0;

  tlb_array #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c),
    .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c),
    .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                       input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                       input logic d0, input logic v0, input logic [19:0] pfn1,
                       input logic [2:0] c1, input logic d1, input logic v1);
    w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [18:0] vpn2,
                             input logic [7:0] asid, input logic g, input logic [19:0] pfn0,
                             input logic [2:0] c0, input logic d0, input logic v0,
                             input logic [19:0] pfn1, input logic [2:0] c1, input logic d1,
                             input logic v1);
    set_w(idx, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1);
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic search0(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
    s0_vpn2 = vpn2; s0_asid = asid; s0_odd_page = odd;
  endtask

  task automatic search1(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
    s1_vpn2 = vpn2; s1_asid = asid; s1_odd_page = odd;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; r_index = '0;
    set_w(4'd0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    search0('0, '0, 1'b0);
    search1('0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // After reset only the all-zero key hits, on entry 0.
    search0(19'h0, 8'h00, 1'b0);
    search1(19'h0, 8'h33, 1'b0);
    #1;
    check("rst_zero_found", 64'(s0_found), 64'd1);
    check("rst_zero_index", 64'(s0_index), 64'd0);
    check("rst_asid_miss", 64'(s1_found), 64'd0);

    // Basic hit, odd/even select, ASID miss.
    write_entry(4'd5, 19'h12345, 8'h0A, 1'b0, 20'h00100, 3'd2, 1'b1, 1'b1,
                20'h00200, 3'd3, 1'b0, 1'b1);
    search0(19'h12345, 8'h0A, 1'b1);
    #1;
    check("hit_found", 64'(s0_found), 64'd1);
    check("hit_index", 64'(s0_index), 64'd5);
    check("hit_pfn_odd", 64'(s0_pfn), 64'h00200);
    check("hit_v_odd", 64'(s0_v), 64'd1);
    check("hit_cd_odd", 64'({s0_c, s0_d}), 64'({3'd3, 1'b0}));
    search0(19'h12345, 8'h0A, 1'b0);
    #1;
    check("hit_even", 64'({s0_pfn, s0_c, s0_d, s0_v}), 64'({20'h00100, 3'd2, 1'b1, 1'b1}));
    search0(19'h12345, 8'h0B, 1'b1);
    #1;
    check("miss_found", 64'(s0_found), 64'd0);
    check("miss_zero", 64'({s0_index, s0_pfn, s0_c, s0_d, s0_v}), 64'd0);

    // Global page ignores ASID.
    write_entry(4'd5, 19'h12345, 8'h0A, 1'b1, 20'h00100, 3'd2, 1'b1, 1'b1,
                20'h00200, 3'd3, 1'b0, 1'b1);
    search0(19'h12345, 8'hFF, 1'b0);
    r_index = 4'd5;
    #1;
    check("g_found", 64'(s0_found), 64'd1);
    check("g_index", 64'(s0_index), 64'd5);
    check("r_g", 64'(r_g), 64'd1);
    check("r_asid", 64'(r_asid), 64'h0A);

    // Duplicate tags: lowest index wins on both ports.
    write_entry(4'd9, 19'h0AAAA, 8'h11, 1'b0, 20'h99999, 3'd1, 1'b0, 1'b1,
                20'h99990, 3'd1, 1'b0, 1'b1);
    write_entry(4'd3, 19'h0AAAA, 8'h11, 1'b0, 20'h33333, 3'd1, 1'b0, 1'b1,
                20'h33330, 3'd1, 1'b0, 1'b1);
    search0(19'h0AAAA, 8'h11, 1'b0);
    search1(19'h0AAAA, 8'h11, 1'b1);
    #1;
    check("dup_idx0", 64'(s0_index), 64'd3);
    check("dup_idx1", 64'(s1_index), 64'd3);
    check("dup_pfn0", 64'(s0_pfn), 64'h33333);
    check("dup_pfn1", 64'(s1_pfn), 64'h33330);

    // Write and search/read the same entry in one cycle: old data first, new next cycle.
    write_entry(4'd7, 19'h07777, 8'h22, 1'b0, 20'h00777, 3'd0, 1'b0, 1'b1,
                20'h00778, 3'd0, 1'b0, 1'b1);
    set_w(4'd7, 19'h7ABCD, 8'h22, 1'b0, 20'h007AB, 3'd0, 1'b0, 1'b1,
          20'h007AC, 3'd0, 1'b0, 1'b1);
    we = 1'b1;
    search1(19'h7ABCD, 8'h22, 1'b0);
    r_index = 4'd7;
    #1;
    check("wr_same_found", 64'(s1_found), 64'd0);
    check("wr_same_rvpn", 64'(r_vpn2), 64'h07777);
    tick();
    we = 1'b0;
    #1;
    check("wr_next_found", 64'(s1_found), 64'd1);
    check("wr_next_index", 64'(s1_index), 64'd7);
    check("wr_next_rvpn", 64'(r_vpn2), 64'h7ABCD);
    check("wr_next_rpfn", 64'(r_pfn0), 64'h007AB);

    // Two ports, two different entries at once; odd half of 14 is invalid.
    write_entry(4'd2, 19'h00222, 8'h02, 1'b0, 20'h02220, 3'd6, 1'b0, 1'b0,
                20'h22222, 3'd3, 1'b1, 1'b1);
    write_entry(4'd14, 19'h0EEEE, 8'h0E, 1'b0, 20'hEEEEE, 3'd5, 1'b0, 1'b1,
                20'hEEEE0, 3'd4, 1'b1, 1'b0);
    search0(19'h00222, 8'h02, 1'b1);
    search1(19'h0EEEE, 8'h0E, 1'b0);
    #1;
    check("dual_idx0", 64'(s0_index), 64'd2);
    check("dual_idx1", 64'(s1_index), 64'd14);
    check("dual_half0", 64'({s0_pfn, s0_c, s0_d, s0_v}), 64'({20'h22222, 3'd3, 1'b1, 1'b1}));
    check("dual_half1", 64'({s1_pfn, s1_c, s1_d, s1_v}), 64'({20'hEEEEE, 3'd5, 1'b0, 1'b1}));
    search1(19'h0EEEE, 8'h0E, 1'b1);
    #1;
    check("inv_found", 64'(s1_found), 64'd1);
    check("inv_v", 64'(s1_v), 64'd0);

    // Reset beats a concurrent write.
    write_entry(4'd4, 19'h44444, 8'h44, 1'b1, 20'h44444, 3'd4, 1'b1, 1'b1,
                20'h44445, 3'd4, 1'b1, 1'b1);
    set_w(4'd4, 19'h55555, 8'h55, 1'b1, 20'h55555, 3'd5, 1'b1, 1'b1,
          20'h55556, 3'd5, 1'b1, 1'b1);
    we = 1'b1;
    reset = 1'b1;
    tick();
    we = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1;
      check($sformatf("rst_read_%0d", i),
            64'({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0}) |
            64'({r_pfn1, r_c1, r_d1, r_v1}), 64'd0);
    end
    search0(19'h55555, 8'h55, 1'b0);
    search1(19'h12345, 8'h0A, 1'b0);
    #1;
    check("rst_no_write", 64'(s0_found), 64'd0);
    check("rst_cleared", 64'(s1_found), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_array.md
TLB_ARRAY -- requirements
Module: tlb_array

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of entries; the index width is fixed at 4 bits.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports s0_vpn2 and s1_vpn2, input, 19: search virtual page pair number (port 0 fetch, port 1 data/tlbp).
REQ-005 SHALL have ports s0_odd_page and s1_odd_page, input, 1: selects the odd (1) or even (0) half of the matched entry.
REQ-006 SHALL have ports s0_asid and s1_asid, input, 8: search ASID.
REQ-007 SHALL have ports s0_found and s1_found, output, 1: hit flag.
REQ-008 SHALL have ports s0_index and s1_index, output, 4: index of the hitting entry.
REQ-009 SHALL have ports sN_pfn (output, 20), sN_c (output, 3), sN_d (output, 1) and sN_v (output, 1) for N=0,1: the selected half-page attributes.
REQ-010 SHALL have port we, input, 1: write enable, one entry per asserted cycle.
REQ-011 SHALL have port w_index, input, 4: the entry to write.
REQ-012 SHALL have ports w_vpn2 (input, 19), w_asid (input, 8) and w_g (input, 1): the write tag.
REQ-013 SHALL have ports w_pfn0/w_pfn1 (input, 20), w_c0/w_c1 (input, 3), w_d0/w_d1 (input, 1) and w_v0/w_v1 (input, 1): the write data for the even/odd halves.
REQ-014 SHALL have port r_index, input, 4: the entry to read.
REQ-015 SHALL have ports r_vpn2 (output, 19), r_asid (output, 8) and r_g (output, 1): the read tag.
REQ-016 SHALL have ports r_pfn0/r_pfn1 (output, 20), r_c0/r_c1 (output, 3), r_d0/r_d1 (output, 1) and r_v0/r_v1 (output, 1): the read data.

Function
REQ-017 SHALL store per entry: vpn2[18:0], asid[7:0], g, and, for each of the even and odd halves, pfn[19:0], c[2:0], d and v.
REQ-018 SHALL, when we=1 at a rising edge, overwrite every field of entry w_index with the w_* values, and SHALL store g as given (the producer supplies g0&g1).
REQ-019 SHALL leave all other entries unchanged on a write.
REQ-020 SHALL, when we=0, hold all entries unchanged.
REQ-021 SHALL treat entry i as matching port N iff vpn2[i]==sN_vpn2 and (g[i]==1 or asid[i]==sN_asid).
REQ-022 SHALL compute the match without regard to v; a matching entry with v=0 gives sN_found=1, sN_v=0.
REQ-023 SHALL compute search outputs combinationally from the current contents, with zero latency.
REQ-024 SHALL, when several entries match, report the lowest index, with pfn/c/d/v taken from that entry.
REQ-025 SHALL select pfn/c/d/v from the odd half when sN_odd_page=1, else from the even half.
REQ-026 SHALL, on a miss, drive sN_found=0 and sN_index, sN_pfn, sN_c, sN_d and sN_v all to 0.
REQ-027 SHALL evaluate ports 0 and 1 independently and concurrently; they never stall each other.
REQ-028 SHALL drive the r_* outputs combinationally from entry r_index.
REQ-029 SHALL return entry r_index's stored g on r_g.
REQ-030 SHALL handle a write and a search/read of the same entry in the same cycle as follows: that cycle's search/read returns the old contents; the new contents are visible from the next cycle (write-then-read latency 1).
REQ-031 SHALL allow w_index and r_index to take any value 0..TLBNUM-1 with no wrap or illegal range.

Reset
REQ-032 SHALL, while reset=1 at a rising edge, clear every field of every entry to 0.
REQ-033 SHALL give reset priority over we.
REQ-034 SHALL, in the cycle after reset, drive s0_found=s1_found=0 for any asid input unless the search key is vpn2=0 and asid=0, in which case entry 0 hits (all-zero tag).
REQ-035 SHALL, when reset is asserted mid-operation, leave no write from that cycle committed.

Verification
REQ-036 SHALL be verified by this scenario: write idx 5 {vpn2=0x12345, asid=0x0A, g=0, pfn0=0x00100, v0=1, pfn1=0x00200, v1=1}; search s0 vpn2=0x12345, asid=0x0A, odd=1 -> found=1, index=5, pfn=0x00200, v=1; then asid=0x0B -> found=0, all outputs 0.
REQ-037 SHALL be verified by this scenario: set g=1 on idx 5, search with asid=0xFF -> found=1, index=5; r_index=5 -> r_g=1, r_asid=0x0A.
REQ-038 SHALL be verified by this scenario: write the same vpn2/asid into idx 3 and idx 9 -> both ports report index=3.
REQ-039 SHALL be verified by this scenario: we=1 on idx 7 with a new vpn2 while s1 searches that vpn2 in the same cycle -> found=0 that cycle, found=1/index=7 next cycle; r_index=7 shows old then new data likewise.
REQ-040 SHALL be verified by this scenario: s0 and s1 search different keys hitting idx 2 and idx 14 simultaneously -> each reports its own index and half-page data.
REQ-041 SHALL be verified by this scenario: populate entries, then assert reset together with we=1 on idx 4 -> all r_* read 0 for every index, and idx 4 is not written.
